multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed below.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising clk.
REQ-004 opcode  in  6  instruction[31:26] from the external instruction register.
REQ-005 funct  in  6  instruction[5:0] from the external instruction register.
REQ-006 zero  in  1  main ALU zero flag, valid in the cycle it is used.
REQ-007 pc_we, ir_we, reg_we, mem_we  out  1 each  write enables for PC, instruction register, register file and unified memory.
REQ-008 iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-010 alu_src_b  out  2  0 = register B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
REQ-011 alu_op  out  3  ALU command: ADD=0, SUB=1, XOR=2, SLT=3.
REQ-012 pc_src  out  2  0 = ALU output, 1 = ALU result register (branch target), 2 = jump address, 3 = register A (jr).
REQ-013 reg_dst  out  2  0 = rt, 1 = rd, 2 = r31.
REQ-014 wb_src  out  2  0 = ALU result register, 1 = memory data register, 2 = PC (already PC+4, used for jal).
REQ-015 state  out  4  current state encoding, for debug.
REQ-016 illegal  out  1  high while in ILLEGAL.
REQ-017 instr_count  out  32  retired-instruction count; see Configuration.

Function
REQ-018 States and encodings SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JUMP=10, JAL=11, JR=12, ILLEGAL=15.
REQ-019 All outputs SHALL be Moore outputs decoded from the state register only, except that pc_we in BRANCH also depends on zero and opcode. Every enable not listed for a state SHALL be 0.
REQ-020 FETCH SHALL assert ir_we and pc_we, with iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD and pc_src=0; next state is DECODE.
REQ-021 DECODE SHALL compute the branch target with alu_src_a=0, alu_src_b=3 and alu_op=ADD, then dispatch:
  - lw 0x23 and sw 0x2B -> MEM_ADDR
  - R-type 0x00 with funct 0x20, 0x22 or 0x2A -> EXEC_R
  - R-type 0x00 with funct 0x08 -> JR
  - addi 0x08 and xori 0x0E -> EXEC_I
  - beq 0x04 and bne 0x05 -> BRANCH
  - j 0x02 -> JUMP
  - jal 0x03 -> JAL
  - any other opcode or funct -> ILLEGAL
REQ-022 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=2 and ADD, then go to MEM_READ for lw or MEM_WRITE for sw. MEM_READ SHALL drive iord=1 and go to MEM_WB. MEM_WB SHALL drive reg_we, reg_dst=0 and wb_src=1, then go to FETCH. MEM_WRITE SHALL drive iord=1 and mem_we, then go to FETCH.
REQ-023 EXEC_R SHALL drive alu_src_a=1 and alu_src_b=0, with alu_op ADD, SUB or SLT for funct 0x20, 0x22 or 0x2A. EXEC_I SHALL drive alu_src_b=2, with alu_op ADD for addi or XOR for xori. Both states go to ALU_WB.
REQ-024 ALU_WB SHALL drive reg_we and wb_src=0, with reg_dst=1 for R-type and 0 otherwise, then go to FETCH.
REQ-025 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, SUB and pc_src=1. It SHALL assert pc_we iff (beq and zero) or (bne and not zero), then go to FETCH.
REQ-026 JUMP SHALL drive pc_we with pc_src=2. JAL SHALL drive pc_we, pc_src=2, reg_we, reg_dst=2 and wb_src=2. JR SHALL drive pc_we with pc_src=3. All three go to FETCH.
REQ-027 ILLEGAL SHALL be sticky until reset, with all enables 0.
REQ-028 Cycles per instruction SHALL be:
  - lw 5
  - sw, R-type ALU, addi, xori 4
  - beq, bne, j, jal, jr 3

Reset
REQ-029 While reset=1 at a rising edge, the state SHALL become FETCH and instr_count SHALL become 0, regardless of the current state, including ILLEGAL and mid-instruction.
REQ-030 In the first cycle after reset deasserts, the FETCH outputs SHALL be driven. No write enable other than those of FETCH SHALL be high in that cycle.

Configuration
REQ-031 Macro MC_INSTR_COUNT_EN:
  - When defined, instr_count SHALL increment by 1 (wrapping 0xFFFFFFFF -> 0) on every transition into FETCH from any state except reset.
  - When undefined, instr_count SHALL be constant 0 and no counter register is synthesized.

Verification
REQ-032 Reset in MEM_READ -> next cycle state=0, ir_we=1, pc_we=1, mem_we=0, instr_count=0.
REQ-033 lw (opcode 0x23) -> state sequence 0,1,2,3,4,0; reg_we=1 only in state 4 with wb_src=1; instr_count +1.
REQ-034 beq with zero=1, then bne with zero=1 -> pc_we=1 in BRANCH for beq, pc_we=0 for bne; each takes 3 cycles.
REQ-035 R-type funct 0x2A -> EXEC_R alu_op=3, ALU_WB reg_dst=1; funct 0x09 -> ILLEGAL, illegal=1 held for 10 cycles until reset.
REQ-036 jal -> JAL cycle has pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_src=2.
REQ-037 With MC_INSTR_COUNT_EN, preload the counter to 0xFFFFFFFF by force and retire j -> instr_count=0; without the macro, instr_count stays 0 throughout.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-subset control FSM; optional retire counter via MC_INSTR_COUNT_EN
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic        iord,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_src,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_JAL       = 4'd11,
        S_JR        = 4'd12,
        S_ILLEGAL   = 4'd15
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t state_q, state_d;

    // State register; reset always returns to FETCH, even out of ILLEGAL
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; opcode/funct come from the external IR, which only changes in FETCH
    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = ALU_ADD;
        pc_src    = 2'd0;
        reg_dst   = 2'd0;
        wb_src    = 2'd0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                alu_src_b = 2'd1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_ADDI, OP_XORI: state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_SLT: state_d = S_EXEC_R;
                            FN_JR:                  state_d = S_JR;
                            default:                state_d = S_ILLEGAL;
                        endcase
                    end
                    default:          state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                iord    = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_we  = 1'b1;
                wb_src  = 2'd1;
                state_d = S_FETCH;
            end
            S_MEM_WRITE: begin
                iord    = 1'b1;
                mem_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_we  = 1'b1;
                reg_dst = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'd1;
                pc_we     = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_we   = 1'b1;
                pc_src  = 2'd2;
                state_d = S_FETCH;
            end
            S_JAL: begin
                pc_we   = 1'b1;
                pc_src  = 2'd2;
                reg_we  = 1'b1;
                reg_dst = 2'd2;
                wb_src  = 2'd2;
                state_d = S_FETCH;
            end
            S_JR: begin
                pc_we   = 1'b1;
                pc_src  = 2'd3;
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_ILLEGAL;
            end
            default: begin
                illegal = 1'b1;
                state_d = S_ILLEGAL;
            end
        endcase
    end

    assign state = state_q;

`ifdef MC_INSTR_COUNT_EN
    logic [31:0] instr_count_q, instr_count_d;

    // Every entry into FETCH retires one instruction; FETCH never loops on itself
    always_comb begin
        instr_count_d = instr_count_q;
        if (state_d == S_FETCH) begin
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    // Retire counter register, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_q <= 32'd0;
        end else begin
            instr_count_q <= instr_count_d;
        end
    end

    assign instr_count = instr_count_q;
`else
    assign instr_count = 32'd0;
`endif

endmodule
